mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multi-cycle MIPS core between two requesters: the instruction-fetch stage (IR load) and the load/store data path.
- Sits between the control block's fetch/data request strobes and the memory model.
- Serialises accesses, inserts a fixed wait-state count, and returns read data with a one-cycle acknowledge.
- Uses round-robin priority when both requesters ask at once.

Parameters:
LAT, 2, memory access latency in cycles (>=1); mem_rdata is valid in the LAT-th ACCESS cycle
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  AW  fetch address
if_ack  out  1  one-cycle fetch completion pulse
if_rdata  out  DW  registered fetched word
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DW  registered load data
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  AW  latched access address
mem_wdata  out  DW  latched store data
mem_rdata  in  DW  memory read data
busy  out  1  high in ACCESS or RESP
owner  out  1  current or last grantee: 0 = fetch, 1 = data
state  out  2  debug: 0 = IDLE, 1 = ACCESS, 2 = RESP

Behaviour:
- Reset: synchronous, takes priority over all other inputs.
  - State returns to IDLE and any in-flight access is aborted; no ack is issued.
  - All outputs go to 0: acks, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, busy, state.
  - last_owner is set to data (owner=1), so fetch wins the first tie.
- IDLE:
  - mem_en=0, mem_we=0.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_owner.
  - On grant: latch addr, plus we and wdata for data (we=0 for fetch); set owner and last_owner; load cnt=LAT-1; go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - mem_en=1; mem_we = latched we.
  - mem_addr and mem_wdata are driven from the latches. Requester addr/wdata changes or req drops are ignored, and the access always completes.
  - While cnt!=0: decrement cnt.
  - When cnt==0:
    - For a read, capture mem_rdata into if_rdata or d_rdata according to owner.
    - Go to RESP.
    - A store leaves d_rdata unchanged.
- RESP:
  - mem_en=0, mem_we=0.
  - The owner's ack is 1 for exactly this cycle.
  - Always go to IDLE next. Requests are not sampled in RESP.
- Latency:
  - A req first seen high at clock edge k produces ACCESS during cycles k+1..k+LAT and ack during cycle k+LAT+1.
  - Minimum spacing between grants is LAT+2 cycles.
- Requester contract:
  - Requesters are registered and drop req at the edge ending the ack cycle.
  - A req still high in the IDLE after RESP is treated as a new request.
- Fairness: under continuous dual requests, grants strictly alternate fetch, data, fetch, ...
- rdata registers hold their value until the next read by the same requester.
- The ack is never asserted for a non-owner. if_ack and d_ack are never high together.

Test Plan:
1. LAT=2, reset released, if_req=1, if_addr=0x0000_0004, memory returns 0x2020_0003 → mem_en high for cycles 1–2; if_ack=1 in cycle 3 with if_rdata=0x2020_0003; owner=0; d_ack stays 0.
2. if_req and d_req both raised in the same cycle right after reset, held until each ack → fetch is served first (ack at cycle 3), then data (ack at cycle 7); with both held high continuously, grant order is F,D,F,D.
3. Data store: d_we=1, d_addr=0x10, d_wdata=0xDEAD_BEEF → mem_we=1 and mem_wdata=0xDEAD_BEEF for exactly the LAT ACCESS cycles; d_ack in cycle LAT+1; d_rdata unchanged.
4. Change d_addr from 0x10 to 0x20 and drop d_req during the first ACCESS cycle → mem_addr stays 0x10; the access completes; d_ack still pulses once.
5. Assert reset in the second ACCESS cycle → next cycle state=0, mem_en=0, no ack, rdata registers=0; the next simultaneous request pair grants fetch first.
6. LAT=1 build, back-to-back fetches with req held → ack every 3 cycles; each if_rdata equals the mem_rdata presented in the single ACCESS cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the core's single memory port: fetch vs. load/store,
// round-robin on ties, fixed LAT-cycle access followed by a one-cycle ack.
module mem_port_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner,
    output logic [1:0]    state
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          gnt_data;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        gnt_data   = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    // owner_q doubles as last_owner: on a tie the other side wins
                    gnt_data = d_req && (!if_req || !owner_q);
                    owner_d  = gnt_data;
                    we_d     = gnt_data && d_we;
                    addr_d   = gnt_data ? d_addr : if_addr;
                    wdata_d  = gnt_data ? d_wdata : wdata_q;
                    cnt_d    = CW'(LAT - 1);
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!we_q) begin
                        if (owner_q) d_rdata_d  = mem_rdata;
                        else         if_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = (state_q == RESP) && !owner_q;
    assign d_ack     = (state_q == RESP) && owner_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign state     = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios on LAT=2 and LAT=1 instances plus
// a randomized run checked against a transaction-timing reference model.
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    logic        clk, reset;
    logic        if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, busy, owner;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  state;
    logic        if_req1, if_ack1, d_req1, d_we1, d_ack1, mem_en1, mem_we1, busy1, owner1;
    logic [31:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic [1:0]  state1;
    int          checks = 0, errors = 0;
    int          en_run;

    mem_port_arbiter #(.LAT(LAT), .AW(32), .DW(32)) u (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .owner(owner), .state(state));

    mem_port_arbiter #(.LAT(1), .AW(32), .DW(32)) u1 (
        .clk(clk), .reset(reset), .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1),
        .if_rdata(if_rdata1), .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_ack(d_ack1), .d_rdata(d_rdata1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1), .owner(owner1), .state(state1));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h4) ? 32'h2020_0003 : ((a * 32'h9E37_79B9) ^ 32'h5A5A_0000);
    endfunction

    // Memory: data is only valid in the LAT-th consecutive enabled cycle, junk otherwise.
    always @(posedge clk) en_run <= (reset || !mem_en) ? 0 : en_run + 1;
    assign mem_rdata  = (mem_en && en_run == LAT - 1) ? mem_word(mem_addr) : (32'hBAD0_0000 ^ 32'(en_run));
    assign mem_rdata1 = mem_en1 ? mem_word(mem_addr1) : 32'hBAD1_0000;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1; if_req = 0; d_req = 0; if_req1 = 0;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; if_req = 1; d_req = 1;
        repeat (3) @(negedge clk);
        checks++; if ({if_ack, d_ack, mem_en, mem_we, busy} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b exp 00000", {if_ack, d_ack, mem_en, mem_we, busy}); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem got %h/%h exp 0", mem_addr, mem_wdata); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0", if_rdata, d_rdata); end
        checks++; if (owner !== 1'b1) begin errors++; $display("FAIL reset_owner got %b exp 1", owner); end
        if_req = 0; d_req = 0; reset = 0;
    endtask

    task automatic test_fetch();
        do_reset();
        if_addr = 32'h4; if_req = 1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (mem_en !== (c <= 2)) begin errors++; $display("FAIL fetch_en c%0d got %b", c, mem_en); end
            checks++; if (if_ack !== (c == 3) || d_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack c%0d got %b/%b", c, if_ack, d_ack); end
            if (c == 3) begin
                checks++; if (if_rdata !== 32'h2020_0003) begin errors++; $display("FAIL fetch_rdata got %h exp 20200003", if_rdata); end
                checks++; if (owner !== 1'b0) begin errors++; $display("FAIL fetch_owner got %b exp 0", owner); end
                if_req = 0;
            end
        end
    endtask

    task automatic test_tie();
        do_reset();
        if_addr = 32'h100; d_addr = 32'h40; d_we = 0; if_req = 1; d_req = 1;
        for (int c = 1; c <= 16; c++) begin
            logic ef, ed;
            @(negedge clk);
            ef = (c % 4 == 3) && (((c - 1) / 4) % 2 == 0);
            ed = (c % 4 == 3) && (((c - 1) / 4) % 2 == 1);
            checks++; if (if_ack !== ef || d_ack !== ed) begin errors++; $display("FAIL tie_ack c%0d got %b%b exp %b%b", c, if_ack, d_ack, ef, ed); end
            if (ef) begin checks++; if (if_rdata !== mem_word(32'h100) || owner !== 1'b0) begin errors++; $display("FAIL tie_f c%0d got %h/%b", c, if_rdata, owner); end end
            if (ed) begin checks++; if (d_rdata !== mem_word(32'h40) || owner !== 1'b1) begin errors++; $display("FAIL tie_d c%0d got %h/%b", c, d_rdata, owner); end end
        end
        if_req = 0; d_req = 0;
    endtask

    task automatic test_store();
        d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_req = 1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (mem_we !== (c <= 2) || mem_en !== (c <= 2)) begin errors++; $display("FAIL store_we c%0d got %b/%b", c, mem_we, mem_en); end
            if (c <= 2) begin checks++; if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h10) begin errors++; $display("FAIL store_bus c%0d got %h@%h", c, mem_wdata, mem_addr); end end
            checks++; if (d_ack !== (c == 3) || if_ack !== 1'b0) begin errors++; $display("FAIL store_ack c%0d got %b/%b", c, d_ack, if_ack); end
            checks++; if (d_rdata !== mem_word(32'h40)) begin errors++; $display("FAIL store_rdata c%0d got %h exp %h", c, d_rdata, mem_word(32'h40)); end
            if (c == 3) begin d_req = 0; d_we = 0; end
        end
    endtask

    task automatic test_ignore();
        d_we = 0; d_addr = 32'h10; d_req = 1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 2) begin checks++; if (mem_addr !== 32'h10 || mem_en !== 1'b1) begin errors++; $display("FAIL ign_addr c%0d got %h/%b exp 10/1", c, mem_addr, mem_en); end end
            checks++; if (d_ack !== (c == 3)) begin errors++; $display("FAIL ign_ack c%0d got %b", c, d_ack); end
            if (c == 3) begin checks++; if (d_rdata !== mem_word(32'h10)) begin errors++; $display("FAIL ign_rdata got %h exp %h", d_rdata, mem_word(32'h10)); end end
            if (c == 1) begin d_addr = 32'h20; d_req = 0; end
        end
    endtask

    task automatic test_reset_mid();
        if_addr = 32'h200; if_req = 1;
        repeat (2) @(negedge clk);
        reset = 1; if_req = 0;
        @(negedge clk);
        checks++; if (state !== 2'd0 || mem_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_state got %0d/%b/%b", state, mem_en, busy); end
        checks++; if (if_ack !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("FAIL rmid_ack got %b/%b exp 0", if_ack, d_ack); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0 || owner !== 1'b1) begin errors++; $display("FAIL rmid_regs got %h/%h/%b", if_rdata, d_rdata, owner); end
        reset = 0; if_addr = 32'h300; d_addr = 32'h50; d_we = 0; if_req = 1; d_req = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++; if (if_ack !== (c == 3) || d_ack !== (c == 7)) begin errors++; $display("FAIL rmid_order c%0d got %b%b", c, if_ack, d_ack); end
            if (c == 3) if_req = 0;
            if (c == 7) d_req = 0;
        end
    endtask

    task automatic test_lat1();
        logic [31:0] ea;
        do_reset();
        ea = 32'h1000; if_addr1 = ea; if_req1 = 1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checks++; if (mem_en1 !== (c % 3 == 1) || if_ack1 !== (c % 3 == 2)) begin errors++; $display("FAIL lat1_tim c%0d got %b/%b", c, mem_en1, if_ack1); end
            if (c % 3 == 2) begin
                checks++; if (if_rdata1 !== mem_word(ea)) begin errors++; $display("FAIL lat1_rdata c%0d got %h exp %h", c, if_rdata1, mem_word(ea)); end
                ea = $urandom & 32'hFFFF_FFFC; if_addr1 = ea;
            end
        end
        if_req1 = 0;
    endtask

    task automatic test_random();
        int          free_at, gnt_cyc, ack_cyc, t;
        logic        who, last, g_we, e_en;
        logic [31:0] g_addr, g_wdata, e_if, e_d;
        do_reset();
        free_at = 0; gnt_cyc = -100; ack_cyc = -100; who = 0; last = 1;
        g_we = 0; g_addr = 0; g_wdata = 0; e_if = 0; e_d = 0;
        for (int n = 0; n < 400; n++) begin
            // Requests visible at edge n; a grant there owns the port until edge n+LAT+2.
            if (n >= free_at && (if_req || d_req)) begin
                who = (if_req && d_req) ? !last : d_req;
                last = who; gnt_cyc = n; ack_cyc = n + LAT + 1; free_at = n + LAT + 2;
                g_we = who & d_we; g_addr = who ? d_addr : if_addr; g_wdata = d_wdata;
            end
            @(negedge clk);
            t = n + 1;
            e_en = (t > gnt_cyc) && (t <= gnt_cyc + LAT);
            if (t == ack_cyc && !g_we) begin
                if (who) e_d = mem_word(g_addr);
                else     e_if = mem_word(g_addr);
            end
            checks++; if (if_ack !== (t == ack_cyc && !who) || d_ack !== (t == ack_cyc && who)) begin errors++; $display("FAIL rnd_ack t%0d got %b%b", t, if_ack, d_ack); end
            checks++; if (mem_en !== e_en || mem_we !== (e_en && g_we)) begin errors++; $display("FAIL rnd_en t%0d got %b%b exp %b%b", t, mem_en, mem_we, e_en, e_en && g_we); end
            if (e_en) begin checks++; if (mem_addr !== g_addr || (g_we && mem_wdata !== g_wdata)) begin errors++; $display("FAIL rnd_bus t%0d got %h/%h exp %h/%h", t, mem_addr, mem_wdata, g_addr, g_wdata); end end
            checks++; if (owner !== last || busy !== (t > gnt_cyc && t <= ack_cyc)) begin errors++; $display("FAIL rnd_own t%0d got %b/%b", t, owner, busy); end
            checks++; if (if_rdata !== e_if || d_rdata !== e_d) begin errors++; $display("FAIL rnd_rdata t%0d got %h/%h exp %h/%h", t, if_rdata, d_rdata, e_if, e_d); end
            if (t == ack_cyc && !who) if_req = 0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC; end
            if (t == ack_cyc && who) d_req = 0;
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            end
        end
        if_req = 0; d_req = 0;
    endtask

    initial begin
        reset = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        if_req1 = 0; if_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
        test_reset();
        test_fetch();
        test_tie();
        test_store();
        test_ignore();
        test_reset_mid();
        test_lat1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
